quant_pack_buffer: RTL

QUANT_PACK_BUFFER -- requirements
Module: quant_pack_buffer

---
 rtl/quant_pack_pkg.sv | 34 +++
 rtl/quant_pack_fifo.sv | 72 +++++++
 rtl/quant_pack_buffer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/quant_pack_pkg.sv
// quant_pack_pkg: shared constants and types for the quantized-byte packer.
//   LANES              bytes per packed word
//   DEFAULT_LATENCY    default quantizer pipeline depth
//   DEFAULT_FIFO_DEPTH default number of buffered packed words
//   strb_t / word_t    byte-valid mask and packed word types
//   entry_t            one FIFO entry {data, strb}
package quant_pack_pkg;

    localparam int LANES              = 4;
    localparam int DEFAULT_LATENCY    = 6;
    localparam int DEFAULT_FIFO_DEPTH = 4;

    typedef logic [3:0]  strb_t;
    typedef logic [31:0] word_t;

    typedef struct packed {
        word_t data;
        strb_t strb;
    } entry_t;

    // Byte mask with the lowest cnt bits set (cnt = 0..4).
    function automatic strb_t strb_for_count(input logic [2:0] cnt);
        strb_t s;
        case (cnt)
            3'd1:    s = 4'b0001;
            3'd2:    s = 4'b0011;
            3'd3:    s = 4'b0111;
            3'd4:    s = 4'b1111;
            default: s = 4'b0000;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/quant_pack_fifo.sv
// quant_pack_fifo: synchronous FIFO of {word, strb} entries.
//   clk, rstn  clock, asynchronous active-low reset
//   push_i     write request (accepted when not full, or when full with pop_i)
//   wdata_i    entry to write
//   pop_i      read request (ignored when empty)
//   rdata_o    head entry
//   full_o     DEPTH entries held
//   empty_o    no entries held
//   level_o    number of entries held
module quant_pack_fifo
    import quant_pack_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          push_i,
    input  entry_t        wdata_i,
    input  logic          pop_i,
    output entry_t        rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [LW-1:0] level_o
);

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] count_q, count_d;
    logic          wr_en;
    logic          rd_en;

    assign full_o  = (count_q == LW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign level_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign wr_en = push_i && (!full_o || pop_i);
    assign rd_en = pop_i && !empty_o;

    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = wdata_i;
        end
        // DEPTH is a power of two, so pointers wrap naturally.
        wr_ptr_d = wr_ptr_q + AW'(wr_en);
        rd_ptr_d = rd_ptr_q + AW'(rd_en);
        count_d  = count_q + LW'(wr_en) - LW'(rd_en);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/quant_pack_buffer.sv
// quant_pack_buffer: packs quantized bytes into 32-bit words and buffers them.
//   clk, rstn     clock, asynchronous active-low reset
//   in_valid_i    valid of the raw sample entering the quantizer
//   q_i           quantizer output byte, LATENCY cycles behind in_valid_i
//   flush_i       emit the partially filled word
//   clr_err_i     clear the sticky overflow flag
//   out_ready_i   downstream ready
//   out_valid_o   packed word available
//   out_data_o    packed word, first byte in bits [7:0]
//   out_strb_o    byte-valid mask of out_data_o
//   fifo_level_o  words held
//   overflow_o    sticky: a word was dropped because the FIFO was full
module quant_pack_buffer
    import quant_pack_pkg::*;
#(
    parameter int LATENCY    = DEFAULT_LATENCY,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             in_valid_i,
    input  logic [7:0]                       q_i,
    input  logic                             flush_i,
    input  logic                             clr_err_i,
    input  logic                             out_ready_i,
    output logic                             out_valid_o,
    output word_t                            out_data_o,
    output strb_t                            out_strb_o,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_level_o,
    output logic                             overflow_o
);

    logic [LATENCY-1:0] vld_dly_q, vld_dly_d;
    logic [1:0]         lane_cnt_q, lane_cnt_d;
    word_t              acc_q, acc_d;
    logic               overflow_q, overflow_d;

    logic               q_vld;
    word_t              acc_ins;
    logic [2:0]         cnt_after;
    logic               push;
    entry_t             push_entry;
    logic               pop;
    logic               drop;
    logic               fifo_full;
    logic               fifo_empty;
    entry_t             head;

    // Output handshake: a word transfers on a cycle where out_valid_o and
    // out_ready_i are both high; while out_valid_o is high and out_ready_i is
    // low the head word and strobe hold steady.
    assign out_valid_o = !fifo_empty;
    assign pop         = out_valid_o && out_ready_i;
    assign out_data_o  = head.data;
    assign out_strb_o  = head.strb;
    assign overflow_o  = overflow_q;

    assign q_vld = vld_dly_q[LATENCY-1];

    always_comb begin
        vld_dly_d[0] = in_valid_i;
        for (int i = 1; i < LATENCY; i++) begin
            vld_dly_d[i] = vld_dly_q[i-1];
        end
    end

    // The byte arriving this cycle is merged first, so a coincident flush
    // carries it and a byte that completes the word yields a single full push.
    always_comb begin
        acc_ins = acc_q;
        if (q_vld) begin
            for (int l = 0; l < LANES; l++) begin
                if (lane_cnt_q == 2'(l)) begin
                    acc_ins[8*l +: 8] = q_i;
                end
            end
        end
        cnt_after       = {1'b0, lane_cnt_q} + {2'b00, q_vld};
        push            = (cnt_after == 3'd4) || (flush_i && (cnt_after != 3'd0));
        push_entry.data = acc_ins;
        push_entry.strb = strb_for_count(cnt_after);

        // Every push, accepted or dropped, restarts packing at lane 0.
        if (push) begin
            acc_d      = '0;
            lane_cnt_d = 2'd0;
        end else begin
            acc_d      = acc_ins;
            lane_cnt_d = cnt_after[1:0];
        end
    end

    assign drop = push && fifo_full && !pop;

    // A new drop wins over a coincident clear.
    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_err_i) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            vld_dly_q  <= '0;
            lane_cnt_q <= 2'd0;
            acc_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            vld_dly_q  <= vld_dly_d;
            lane_cnt_q <= lane_cnt_d;
            acc_q      <= acc_d;
            overflow_q <= overflow_d;
        end
    end

    quant_pack_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .level_o (fifo_level_o)
    );

endmodule
